param_hex_counter: RTL and testbench

- Parametrised successor to the team's fixed 16-bit T-flip-flop counter.
- Synchronous up/down counter, DIGITS hex digits wide, with the following features:
  - programmable wrap value (MAX_VAL)
  - synchronous parallel load
  - terminal-count output
  - one seven-segment decoder per nibble
- Sits between board switches/keys and the HEX displays on the FPGA board. Also reused as a timebase/event counter by other labs.

---
 rtl/param_hex_counter.sv | 90 +++++++++
 tb/tb_param_hex_counter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/param_hex_counter.sv
// Parametrised DIGITS-wide hex up/down counter: programmable wrap value, clamped parallel load,
// cascade terminal count and per-nibble 7-segment decode. Optional sticky Ovf: PARAM_HEX_COUNTER_OVF_STICKY_EN.
module param_hex_counter #(
   parameter int                    DIGITS  = 4,
   parameter logic [4*DIGITS-1:0]   MAX_VAL = {(4*DIGITS){1'b1}}
) (
   input  logic                     Clk,
   input  logic                     ClrN,
   input  logic                     En,
   input  logic                     Up,
   input  logic                     Load,
   input  logic [4*DIGITS-1:0]      LoadVal,
   output logic [4*DIGITS-1:0]      Q,
   output logic                     Tc,
   output logic [7*DIGITS-1:0]      HEX
`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
   ,
   output logic                     Ovf
`endif
);

   localparam int W = 4*DIGITS;
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] q_next;
   logic         at_max;
   logic         at_zero;
   logic         wrap;

   assign at_max  = (Q == MAX_VAL);
   assign at_zero = (Q == '0);
   assign wrap    = En & ~Load & ((Up & at_max) | (~Up & at_zero));

   // Gated by ClrN so a cleared counter at zero counting down does not fire downstream stages.
   assign Tc = ClrN & wrap;

   always_comb begin
      q_next = Q;
      if (Load) begin
         q_next = (LoadVal > MAX_VAL) ? MAX_VAL : LoadVal;
      end else if (En) begin
         if (Up) q_next = at_max  ? '0      : Q + ONE;
         else    q_next = at_zero ? MAX_VAL : Q - ONE;
      end
   end

   always_ff @(posedge Clk or negedge ClrN) begin
      if (!ClrN) Q <= '0;
      else       Q <= q_next;
   end

`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
   always_ff @(posedge Clk or negedge ClrN) begin
      if (!ClrN)     Ovf <= 1'b0;
      else if (Load) Ovf <= 1'b0;
      else if (wrap) Ovf <= 1'b1;
   end
`endif

   // Active-low segments, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      s = 7'b1111111;
      case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         4'hF: s = 7'b0001110;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign HEX[7*k +: 7] = seg7(Q[4*k +: 4]);
   end

endmodule

// File: tb/tb_param_hex_counter.sv
// Directed bench for param_hex_counter: a default 4-digit instance and a cascaded pair of
// single-digit decade counters (MAX_VAL=9).
module tb_param_hex_counter;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        clr4, en4, up4, ld4;
   logic [15:0] lv4, q4;
   logic        tc4;
   logic [27:0] hex4;

   logic        clr9, en9, up9, ld9;
   logic [3:0]  lv9, qa, qb;
   logic        tca, tcb;
   logic [6:0]  hexa, hexb;

`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
   logic ovf4, ovfa, ovfb;
`endif

   param_hex_counter #(.DIGITS(4)) u4 (
      .Clk(clk), .ClrN(clr4), .En(en4), .Up(up4), .Load(ld4), .LoadVal(lv4),
      .Q(q4), .Tc(tc4), .HEX(hex4)
`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
      , .Ovf(ovf4)
`endif
   );

   param_hex_counter #(.DIGITS(1), .MAX_VAL(4'd9)) u9a (
      .Clk(clk), .ClrN(clr9), .En(en9), .Up(up9), .Load(ld9), .LoadVal(lv9),
      .Q(qa), .Tc(tca), .HEX(hexa)
`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
      , .Ovf(ovfa)
`endif
   );

   param_hex_counter #(.DIGITS(1), .MAX_VAL(4'd9)) u9b (
      .Clk(clk), .ClrN(clr9), .En(tca), .Up(1'b1), .Load(1'b0), .LoadVal(4'd0),
      .Q(qb), .Tc(tcb), .HEX(hexb)
`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
      , .Ovf(ovfb)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr4 = 1'b0; en4 = 1'b1; up4 = 1'b0; ld4 = 1'b0; lv4 = 16'h0;
      clr9 = 1'b0; en9 = 1'b0; up9 = 1'b1; ld9 = 1'b0; lv9 = 4'h0;
      tick();
      tick();
      check("rst_q", q4, 16'h0000);
      check("rst_hex", hex4, {4{7'b1000000}});
      check("rst_tc_gated", tc4, 1'b0);

      // asynchronous clear mid-count
      clr4 = 1'b1; clr9 = 1'b1; en4 = 1'b0;
      ld4 = 1'b1; lv4 = 16'h0123;
      tick();
      ld4 = 1'b0;
      check("load_0123", q4, 16'h0123);
      en4 = 1'b1; up4 = 1'b0;
      #3;
      clr4 = 1'b0;
      #1;
      check("async_clr_q", q4, 16'h0000);
      check("async_clr_hex", hex4, {4{7'b1000000}});
      check("async_clr_tc", tc4, 1'b0);
      clr4 = 1'b1;

      // up count across a digit carry
      ld4 = 1'b1; lv4 = 16'h0FFE; en4 = 1'b1; up4 = 1'b1;
      tick();
      ld4 = 1'b0;
      #1;
      check("up_load_q", q4, 16'h0FFE);
      check("up_load_tc", tc4, 1'b0);
      tick();
      check("up_q1", q4, 16'h0FFF);
      check("up_hex1_F", hex4[13:7], 7'b0001110);
      check("up_tc1", tc4, 1'b0);
      tick();
      check("up_q2", q4, 16'h1000);
      check("up_hex1_0", hex4[13:7], 7'b1000000);
      check("up_tc2", tc4, 1'b0);
      tick();
      check("up_q3", q4, 16'h1001);
      check("up_tc3", tc4, 1'b0);

      // hold
      ld4 = 1'b1; lv4 = 16'h00A5; en4 = 1'b0;
      tick();
      ld4 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("hold_q", q4, 16'h00A5);
      check("hold_hex0", hex4[6:0], 7'b0010010);
      check("hold_hex1", hex4[13:7], 7'b0001000);
      check("hold_tc", tc4, 1'b0);

      // full-range wrap at default MAX_VAL
      ld4 = 1'b1; lv4 = 16'hFFFF; en4 = 1'b1; up4 = 1'b1;
      tick();
      ld4 = 1'b0;
      #1;
      check("max_q", q4, 16'hFFFF);
      check("max_tc", tc4, 1'b1);
      tick();
      check("max_wrap_q", q4, 16'h0000);
      check("max_wrap_tc", tc4, 1'b0);
`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
      check("max_wrap_ovf", ovf4, 1'b1);
`endif

      // decade wrap up then down
      ld9 = 1'b1; lv9 = 4'd8; en9 = 1'b0;
      tick();
      ld9 = 1'b0; en9 = 1'b1; up9 = 1'b1;
      #1;
      check("dec_q8", qa, 4'd8);
      check("dec_tc8", tca, 1'b0);
      tick();
      check("dec_q9", qa, 4'd9);
      check("dec_tc9", tca, 1'b1);
      check("dec_hex9", hexa, 7'b0010000);
      tick();
      check("dec_wrap_q", qa, 4'd0);
      check("dec_wrap_tc_up", tca, 1'b0);
`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
      check("dec_ovf_set", ovfa, 1'b1);
`endif
      up9 = 1'b0;
      #1;
      check("dec_tc_down0", tca, 1'b1);
      tick();
      check("dec_down_wrap_q", qa, 4'd9);
      check("dec_tc_down9", tca, 1'b0);

      // load clamp and priority over a pending wrap
      up9 = 1'b1; ld9 = 1'b1; lv9 = 4'd12;
      #1;
      check("clamp_tc_load", tca, 1'b0);
      tick();
      ld9 = 1'b0; en9 = 1'b0;
      check("clamp_q", qa, 4'd9);
`ifdef PARAM_HEX_COUNTER_OVF_STICKY_EN
      check("clamp_ovf_clr", ovfa, 1'b0);
`endif

      // cascaded decade counters
      clr9 = 1'b0;
      #1;
      check("casc_rst_a", qa, 4'd0);
      check("casc_rst_b", qb, 4'd0);
      en9 = 1'b1; up9 = 1'b1; ld9 = 1'b0;
      clr9 = 1'b1;
      for (int i = 0; i < 25; i++) tick();
      check("casc_units", qa, 4'd5);
      check("casc_tens", qb, 4'd2);
      check("casc_hex_units", hexa, 7'b0010010);
      check("casc_hex_tens", hexb, 7'b0100100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
